// File: rtl/serial_mac_ctrl_pkg.sv
// Shared types and helpers for the serial multiply-accumulate controller.
//   state_t    : controller FSM states
//   sat_sel_t  : saturation decision (overflow flag + clip direction)
//   sat_add    : classifies a sum carried one bit wider than its target width
//   widths_ok  : elaboration-time consistency check of the width parameters
package serial_mac_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ISSUE = 3'd1,
        WAIT  = 3'd2,
        ACC   = 3'd3,
        OUT   = 3'd4
    } state_t;

    typedef struct packed {
        logic ovf;
        logic neg;
    } sat_sel_t;

    localparam int MIN_OPERAND_W = 1;

    // The product must hold either operand and the accumulator must hold the product.
    function automatic bit widths_ok(input int a_w, input int b_w, input int res_w, input int acc_w);
        return (a_w >= MIN_OPERAND_W) && (b_w >= MIN_OPERAND_W) &&
               (res_w >= a_w) && (res_w >= b_w) && (acc_w >= res_w);
    endfunction

    // For a W+1 bit two's-complement sum, the top two bits differ exactly when the
    // true result does not fit in W bits; the top bit then gives the clip direction.
    function automatic sat_sel_t sat_add(input logic top, input logic msb);
        sat_sel_t sel;
        sel.ovf = top ^ msb;
        sel.neg = top;
        return sel;
    endfunction

endpackage

// File: rtl/serial_mac_ctrl_if.sv
// Operand-pair input stream and accumulated-sum output stream of serial_mac_ctrl.
//   s_valid/s_ready/s_a/s_b/s_last : operand pair stream into the controller
//   m_valid/m_ready/m_acc/m_ovf    : saturated sum stream out of the controller
//   master modport: the producer/consumer around the controller
//   slave  modport: the controller itself
interface serial_mac_ctrl_if #(
    parameter int N_BITS_A = 8,
    parameter int N_BITS_B = 8,
    parameter int ACC_W    = 24
);
    logic                s_valid;
    logic                s_ready;
    logic [N_BITS_A-1:0] s_a;
    logic [N_BITS_B-1:0] s_b;
    logic                s_last;
    logic                m_valid;
    logic                m_ready;
    logic [ACC_W-1:0]    m_acc;
    logic                m_ovf;

    modport master (
        output s_valid, s_a, s_b, s_last, m_ready,
        input  s_ready, m_valid, m_acc, m_ovf
    );

    modport slave (
        input  s_valid, s_a, s_b, s_last, m_ready,
        output s_ready, m_valid, m_acc, m_ovf
    );
endinterface

// File: rtl/serial_mac_ctrl_sat_adder.sv
// Saturating two's-complement adder (the sat_adder stage of the MAC controller).
//   i_a, i_b : W-bit signed addends
//   o_sum    : sum clipped to [-2^(W-1), 2^(W-1)-1]
//   o_ovf    : high when clipping took place
module serial_mac_ctrl_sat_adder
    import serial_mac_ctrl_pkg::*;
#(
    parameter int W = 24
) (
    input  logic [W-1:0] i_a,
    input  logic [W-1:0] i_b,
    output logic [W-1:0] o_sum,
    output logic         o_ovf
);
    logic [W:0] w_wide;
    sat_sel_t   w_sel;

    // Add one bit wide so the wrap is visible, then clip toward the overflow direction.
    always_comb begin
        w_wide = {i_a[W-1], i_a} + {i_b[W-1], i_b};
        w_sel  = sat_add(w_wide[W], w_wide[W-1]);
        if (w_sel.ovf) begin
            if (w_sel.neg) begin
                o_sum = {1'b1, {(W-1){1'b0}}};
            end else begin
                o_sum = {1'b0, {(W-1){1'b1}}};
            end
        end else begin
            o_sum = w_wide[W-1:0];
        end
        o_ovf = w_sel.ovf;
    end
endmodule

// File: rtl/serial_mac_ctrl.sv
// Serial MAC controller: takes operand pairs from a valid/ready stream, hands each pair
// to an external serial multiplier, and accumulates the sign-extended products with
// saturation. The pair tagged last closes the sum, which is then offered downstream.
//   clk, reset         : rising-edge clock, asynchronous active-high reset
//   bus (slave)        : operand pair input stream and sum output stream
//   o_mul_start        : one-cycle start pulse to the multiplier
//   o_mul_a, o_mul_b   : registered operands to the multiplier
//   i_mul_data_ready   : multiplier done/idle (sampled from the first cycle after start)
//   i_mul_result       : multiplier product
module serial_mac_ctrl
    import serial_mac_ctrl_pkg::*;
#(
    parameter int N_BITS_A      = 8,
    parameter int N_BITS_B      = 8,
    parameter int N_BITS_RESULT = 16,
    parameter int ACC_W         = 24
) (
    input  logic                     clk,
    input  logic                     reset,
    serial_mac_ctrl_if.slave         bus,
    output logic                     o_mul_start,
    output logic [N_BITS_A-1:0]      o_mul_a,
    output logic [N_BITS_B-1:0]      o_mul_b,
    input  logic                     i_mul_data_ready,
    input  logic [N_BITS_RESULT-1:0] i_mul_result
);
    if (!widths_ok(N_BITS_A, N_BITS_B, N_BITS_RESULT, ACC_W)) begin : g_width_error
        $error("serial_mac_ctrl: inconsistent width parameters");
    end

    state_t                   r_state;
    state_t                   w_next;
    logic                     r_s_ready;
    logic                     r_mul_start;
    logic                     r_m_valid;
    logic                     r_last;
    logic                     r_ovf;
    logic                     r_m_ovf;
    logic [N_BITS_A-1:0]      r_mul_a;
    logic [N_BITS_B-1:0]      r_mul_b;
    logic [N_BITS_RESULT-1:0] r_prod;
    logic [ACC_W-1:0]         r_acc;
    logic [ACC_W-1:0]         r_m_acc;
    logic                     w_accept;
    logic                     w_add_ovf;
    logic [ACC_W-1:0]         w_prod_ext;
    logic [ACC_W-1:0]         w_sum;

    // s_ready is a registered copy of "state is IDLE", so it alone qualifies acceptance.
    assign w_accept   = r_s_ready & bus.s_valid;
    assign w_prod_ext = ACC_W'(signed'(r_prod));

    serial_mac_ctrl_sat_adder #(.W(ACC_W)) u_sat_adder (
        .i_a   (r_acc),
        .i_b   (w_prod_ext),
        .o_sum (w_sum),
        .o_ovf (w_add_ovf)
    );

    // Next-state decode.
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next = ISSUE;
                end else begin
                    w_next = IDLE;
                end
            end
            ISSUE: w_next = WAIT;
            WAIT: begin
                if (i_mul_data_ready) begin
                    w_next = ACC;
                end else begin
                    w_next = WAIT;
                end
            end
            ACC: begin
                if (r_last) begin
                    w_next = OUT;
                end else begin
                    w_next = IDLE;
                end
            end
            OUT: begin
                if (bus.m_ready) begin
                    w_next = IDLE;
                end else begin
                    w_next = OUT;
                end
            end
            default: w_next = IDLE;
        endcase
    end

    // State register; handshake/control outputs are registered from the next state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_s_ready   <= 1'b0;
            r_mul_start <= 1'b0;
            r_m_valid   <= 1'b0;
        end else begin
            r_state     <= w_next;
            r_s_ready   <= (w_next == IDLE);
            r_mul_start <= (w_next == ISSUE);
            r_m_valid   <= (w_next == OUT);
        end
    end

    // Operand, product, accumulator and output-sum registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_mul_a <= {N_BITS_A{1'b0}};
            r_mul_b <= {N_BITS_B{1'b0}};
            r_last  <= 1'b0;
            r_prod  <= {N_BITS_RESULT{1'b0}};
            r_acc   <= {ACC_W{1'b0}};
            r_ovf   <= 1'b0;
            r_m_acc <= {ACC_W{1'b0}};
            r_m_ovf <= 1'b0;
        end else begin
            if (w_accept) begin
                r_mul_a <= bus.s_a;
                r_mul_b <= bus.s_b;
                r_last  <= bus.s_last;
            end
            if ((r_state == WAIT) && i_mul_data_ready) begin
                r_prod <= i_mul_result;
            end
            if (r_state == ACC) begin
                r_acc <= w_sum;
                r_ovf <= r_ovf | w_add_ovf;
                // The closing sum is copied out here so it stays frozen during back-pressure.
                if (r_last) begin
                    r_m_acc <= w_sum;
                    r_m_ovf <= r_ovf | w_add_ovf;
                end
            end
            if ((r_state == OUT) && bus.m_ready) begin
                r_acc <= {ACC_W{1'b0}};
                r_ovf <= 1'b0;
            end
        end
    end

    assign bus.s_ready = r_s_ready;
    assign bus.m_valid = r_m_valid;
    assign bus.m_acc   = r_m_acc;
    assign bus.m_ovf   = r_m_ovf;
    assign o_mul_start = r_mul_start;
    assign o_mul_a     = r_mul_a;
    assign o_mul_b     = r_mul_b;
endmodule

// File: tb/tb_serial_mac_ctrl.sv
// Scoreboard bench for serial_mac_ctrl. dut0 uses ACC_W=24, dut1 uses ACC_W=16 for the
// saturation case. Each DUT is paired with a behavioural serial multiplier whose latency
// is 1 cycle for a==0 or b==1, otherwise 3..6 cycles.
module tb_serial_mac_ctrl;
    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    serial_mac_ctrl_if #(.N_BITS_A(8), .N_BITS_B(8), .ACC_W(24)) if0 ();
    serial_mac_ctrl_if #(.N_BITS_A(8), .N_BITS_B(8), .ACC_W(16)) if1 ();

    logic        m0_start, m1_start;
    logic [7:0]  m0_a, m0_b, m1_a, m1_b;
    logic [15:0] m0_res, m1_res;
    logic        m0_rdy, m1_rdy;
    int          m0_cnt, m1_cnt;

    assign m0_rdy = (m0_cnt == 0);
    assign m1_rdy = (m1_cnt == 0);

    serial_mac_ctrl #(.N_BITS_A(8), .N_BITS_B(8), .N_BITS_RESULT(16), .ACC_W(24)) dut0 (
        .clk(clk), .reset(reset), .bus(if0),
        .o_mul_start(m0_start), .o_mul_a(m0_a), .o_mul_b(m0_b),
        .i_mul_data_ready(m0_rdy), .i_mul_result(m0_res)
    );

    serial_mac_ctrl #(.N_BITS_A(8), .N_BITS_B(8), .N_BITS_RESULT(16), .ACC_W(16)) dut1 (
        .clk(clk), .reset(reset), .bus(if1),
        .o_mul_start(m1_start), .o_mul_a(m1_a), .o_mul_b(m1_b),
        .i_mul_data_ready(m1_rdy), .i_mul_result(m1_res)
    );

    function automatic logic [15:0] mul16(input logic [7:0] a, input logic [7:0] b);
        logic signed [15:0] x, y;
        x = $signed(a);
        y = $signed(b);
        return x * y;
    endfunction

    function automatic int mul_lat(input logic [7:0] a, input logic [7:0] b);
        if (a == 8'd0 || b == 8'd1) return 1;
        else return 3 + int'(a[1:0]);
    endfunction

    function automatic longint sat_step(input longint acc, input longint p, input int w,
                                        input bit ovf_in, output bit ovf_out);
        longint s, hi, lo;
        s = acc + p;
        hi = (longint'(1) << (w - 1)) - 1;
        lo = -(longint'(1) << (w - 1));
        ovf_out = ovf_in;
        if (s > hi) begin s = hi; ovf_out = 1'b1; end
        else if (s < lo) begin s = lo; ovf_out = 1'b1; end
        return s;
    endfunction

    // Behavioural multipliers: result loads on start, ready drops for latency-1 cycles.
    always @(posedge clk or posedge reset) begin
        if (reset) begin m0_cnt <= 0; m0_res <= 16'd0; end
        else if (m0_start) begin m0_cnt <= mul_lat(m0_a, m0_b) - 1; m0_res <= mul16(m0_a, m0_b); end
        else if (m0_cnt > 0) m0_cnt <= m0_cnt - 1;
    end
    always @(posedge clk or posedge reset) begin
        if (reset) begin m1_cnt <= 0; m1_res <= 16'd0; end
        else if (m1_start) begin m1_cnt <= mul_lat(m1_a, m1_b) - 1; m1_res <= mul16(m1_a, m1_b); end
        else if (m1_cnt > 0) m1_cnt <= m1_cnt - 1;
    end

    logic [24:0] exp0_q[$];   // {ovf, acc}
    logic [16:0] exp1_q[$];
    logic [15:0] op0_q[$];    // {a, b}
    logic [15:0] op1_q[$];
    int accepts0 = 0, starts0 = 0, accepts1 = 0, starts1 = 0;
    bit rnd_mode = 1'b0;
    bit mready_force = 1'b1;

    always @(posedge clk) begin
        #1;
        if0.m_ready = rnd_mode ? 1'($urandom_range(0, 1)) : mready_force;
        if1.m_ready = 1'b1;
    end

    logic [24:0] e0;
    logic [15:0] o0;
    always @(negedge clk) begin
        if (!reset) begin
            if (if0.m_valid && if0.m_ready) begin
                n_checks++;
                if (exp0_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sum0_unexpected: m_acc=%0d, none expected", $signed(if0.m_acc));
                end else begin
                    e0 = exp0_q.pop_front();
                    if ({if0.m_ovf, if0.m_acc} !== e0) begin
                        n_errors++;
                        $display("FAIL sum0: m_acc=%0d m_ovf=%0b, required m_acc=%0d m_ovf=%0b",
                                 $signed(if0.m_acc), if0.m_ovf, $signed(e0[23:0]), e0[24]);
                    end
                end
            end
            if (m0_start) begin
                starts0++;
                n_checks++;
                if (op0_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL start0_unexpected: mul_a=%0d mul_b=%0d", m0_a, m0_b);
                end else begin
                    o0 = op0_q.pop_front();
                    if ({m0_a, m0_b} !== o0) begin
                        n_errors++;
                        $display("FAIL operands0: mul_a=%h mul_b=%h, required %h %h", m0_a, m0_b, o0[15:8], o0[7:0]);
                    end
                end
            end
            if (if0.s_valid && if0.s_ready) accepts0++;
        end
    end

    logic [16:0] e1;
    logic [15:0] o1;
    always @(negedge clk) begin
        if (!reset) begin
            if (if1.m_valid && if1.m_ready) begin
                n_checks++;
                if (exp1_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL sum1_unexpected: m_acc=%0d, none expected", $signed(if1.m_acc));
                end else begin
                    e1 = exp1_q.pop_front();
                    if ({if1.m_ovf, if1.m_acc} !== e1) begin
                        n_errors++;
                        $display("FAIL sum1: m_acc=%0d m_ovf=%0b, required m_acc=%0d m_ovf=%0b",
                                 $signed(if1.m_acc), if1.m_ovf, $signed(e1[15:0]), e1[16]);
                    end
                end
            end
            if (m1_start) begin
                starts1++;
                n_checks++;
                if (op1_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL start1_unexpected: mul_a=%0d mul_b=%0d", m1_a, m1_b);
                end else begin
                    o1 = op1_q.pop_front();
                    if ({m1_a, m1_b} !== o1) begin
                        n_errors++;
                        $display("FAIL operands1: mul_a=%h mul_b=%h, required %h %h", m1_a, m1_b, o1[15:8], o1[7:0]);
                    end
                end
            end
            if (if1.s_valid && if1.s_ready) accepts1++;
        end
    end

    task automatic send0(input logic [7:0] a, input logic [7:0] b, input bit last);
        int guard;
        op0_q.push_back({a, b});
        if0.s_a = a; if0.s_b = b; if0.s_last = last; if0.s_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!if0.s_ready && guard < 200) begin guard++; @(negedge clk); end
        if (!if0.s_ready) begin
            n_checks++; n_errors++;
            $display("FAIL send0_timeout: s_ready=%0b, required 1", if0.s_ready);
        end
        @(posedge clk); #1;
        if0.s_valid = 1'b0;
    endtask

    task automatic send1(input logic [7:0] a, input logic [7:0] b, input bit last);
        int guard;
        op1_q.push_back({a, b});
        if1.s_a = a; if1.s_b = b; if1.s_last = last; if1.s_valid = 1'b1;
        guard = 0;
        @(negedge clk);
        while (!if1.s_ready && guard < 200) begin guard++; @(negedge clk); end
        if (!if1.s_ready) begin
            n_checks++; n_errors++;
            $display("FAIL send1_timeout: s_ready=%0b, required 1", if1.s_ready);
        end
        @(posedge clk); #1;
        if1.s_valid = 1'b0;
    endtask

    task automatic drain(input int max_cycles);
        int g;
        g = 0;
        while ((exp0_q.size() != 0 || exp1_q.size() != 0) && g < max_cycles) begin
            @(negedge clk); g++;
        end
        if (exp0_q.size() != 0 || exp1_q.size() != 0) begin
            n_checks++; n_errors++;
            $display("FAIL drain_timeout: pending sums=%0d/%0d, required 0/0", exp0_q.size(), exp1_q.size());
        end
        @(posedge clk); #1;
    endtask

    task automatic check_reset0(input string tag);
        n_checks++;
        if (if0.s_ready !== 1'b0 || m0_start !== 1'b0 || m0_a !== 8'd0 || m0_b !== 8'd0 ||
            if0.m_valid !== 1'b0 || if0.m_acc !== 24'd0 || if0.m_ovf !== 1'b0) begin
            n_errors++;
            $display("FAIL %s: s_ready=%b start=%b a=%h b=%h m_valid=%b m_acc=%h m_ovf=%b, required all 0",
                     tag, if0.s_ready, m0_start, m0_a, m0_b, if0.m_valid, if0.m_acc, if0.m_ovf);
        end
    endtask

    initial begin : main
        int lat;
        int np;
        int gap;
        int g;
        bit o;
        longint macc;
        bit movf;
        logic [7:0] ra, rb;

        reset = 1'b1;
        if0.s_valid = 1'b0; if0.s_a = 8'd0; if0.s_b = 8'd0; if0.s_last = 1'b0;
        if1.s_valid = 1'b0; if1.s_a = 8'd0; if1.s_b = 8'd0; if1.s_last = 1'b0;
        repeat (3) @(negedge clk);
        check_reset0("reset0_initial");
        n_checks++;
        if (if1.s_ready !== 1'b0 || if1.m_valid !== 1'b0 || if1.m_acc !== 16'd0 || m1_start !== 1'b0) begin
            n_errors++;
            $display("FAIL reset1_initial: s_ready=%b m_valid=%b m_acc=%h start=%b, required all 0",
                     if1.s_ready, if1.m_valid, if1.m_acc, m1_start);
        end
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;

        // (3,4) + (-2,5) = 12 - 10 = 2
        exp0_q.push_back({1'b0, 24'd2});
        send0(8'd3, 8'd4, 1'b0);
        send0(8'hFE, 8'd5, 1'b1);
        drain(200);

        // (0,-7): single WAIT cycle, m_valid in the 4th cycle after the accept cycle
        exp0_q.push_back({1'b0, 24'd0});
        send0(8'd0, 8'hF9, 1'b1);
        lat = 0;
        for (int n = 1; n <= 12 && lat == 0; n++) begin
            @(negedge clk);
            if (if0.m_valid) lat = n;
        end
        n_checks++;
        if (lat != 4) begin
            n_errors++;
            $display("FAIL latency_zero_operand: m_valid after %0d cycles, required 4", lat);
        end
        drain(200);

        // ACC_W=16: 3 x 16129 = 48387 clips to 32767 with ovf; next sum starts clean
        exp1_q.push_back({1'b1, 16'd32767});
        send1(8'd127, 8'd127, 1'b0);
        send1(8'd127, 8'd127, 1'b0);
        send1(8'd127, 8'd127, 1'b1);
        drain(300);
        exp1_q.push_back({1'b0, 16'd1});
        send1(8'd1, 8'd1, 1'b1);
        drain(200);

        // Back-pressure: hold m_ready low for 10 cycles in OUT with a pair waiting
        mready_force = 1'b0;
        @(posedge clk); #1;
        exp0_q.push_back({1'b0, 24'd30});
        send0(8'd5, 8'd6, 1'b1);
        g = 0;
        while (!if0.m_valid && g < 50) begin @(negedge clk); g++; end
        if (!if0.m_valid) begin
            n_checks++; n_errors++;
            $display("FAIL mvalid_timeout: m_valid=%b, required 1", if0.m_valid);
        end
        if0.s_a = 8'd9; if0.s_b = 8'd9; if0.s_last = 1'b1; if0.s_valid = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            n_checks++;
            if (if0.m_acc !== 24'd30 || if0.m_valid !== 1'b1 || if0.s_ready !== 1'b0 || m0_start !== 1'b0) begin
                n_errors++;
                $display("FAIL hold_cycle%0d: m_acc=%0d m_valid=%b s_ready=%b start=%b, required 30 1 0 0",
                         k, if0.m_acc, if0.m_valid, if0.s_ready, m0_start);
            end
        end
        if0.s_valid = 1'b0;
        mready_force = 1'b1;
        drain(200);

        // Reset while the multiplier is busy (WAIT), then a fresh sum
        send0(8'd3, 8'd5, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check_reset0("reset0_in_wait");
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        exp0_q.push_back({1'b0, 24'd6});
        send0(8'd2, 8'd3, 1'b1);
        drain(200);

        // Random pairs, random gaps and random m_ready against a golden accumulator
        rnd_mode = 1'b1;
        macc = 0; movf = 1'b0;
        for (int s = 0; s < 6; s++) begin
            np = $urandom_range(1, 4);
            for (int k = 0; k < np; k++) begin
                gap = $urandom_range(0, 3);
                repeat (gap) begin @(posedge clk); #1; end
                ra = 8'($urandom_range(0, 255));
                rb = 8'($urandom_range(0, 255));
                if (k == 1) rb = 8'd1;
                macc = sat_step(macc, longint'($signed(mul16(ra, rb))), 24, movf, o);
                movf = o;
                if (k == np - 1) begin
                    exp0_q.push_back({movf, macc[23:0]});
                    macc = 0; movf = 1'b0;
                end
                send0(ra, rb, (k == np - 1));
            end
        end
        drain(2000);
        rnd_mode = 1'b0;
        repeat (3) @(negedge clk);

        n_checks++;
        if (starts0 != accepts0 || starts1 != accepts1 || op0_q.size() != 0 || op1_q.size() != 0) begin
            n_errors++;
            $display("FAIL start_count: starts=%0d/%0d accepts=%0d/%0d pending=%0d/%0d, required equal and 0",
                     starts0, starts1, accepts0, accepts1, op0_q.size(), op1_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
